div_seq: RTL

//  Multi-cycle radix-2 signed/unsigned divider sequencer for the EX stage. Started by decoded
//  div/divu; holds the pipeline via stallreq while iterating and returns {hi=rem, lo=quot} for
//  the HI/LO writeback. One bit of quotient per cycle; divide-by-zero takes a fast exit.

---
 rtl/div_seq_pkg.sv | 18 +
 rtl/div_step.sv | 23 ++
 rtl/div_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential divider.
package div_seq_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = 6;

  // Sequencer states; encoding is visible to debug and must stay fixed.
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the partial
// remainder and shift in the next quotient bit.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W:0] cur,
  input  logic [DATA_W-1:0] divisor,
  output logic [2*DATA_W:0] next_c
);

  logic [DATA_W:0] trial;

  // No borrow keeps the difference and sets the quotient bit, else plain shift.
  always_comb begin
    trial = cur[2*DATA_W:DATA_W] - {1'b0, divisor};
    if (!trial[DATA_W]) begin
      next_c = {trial[DATA_W-1:0], cur[DATA_W-1:0], 1'b1};
    end else begin
      next_c = {cur[2*DATA_W-1:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider sequencer for the EX stage.
// Produces {remainder, quotient} one quotient bit per cycle and holds the
// pipeline through stallreq while iterating.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W,
  parameter int unsigned CNT_W  = DIV_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic                  annul,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stallreq
);

  localparam int unsigned DVD_W = 2 * DATA_W + 1;

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DVD_W-1:0]    dividend_q, dividend_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                op1_neg, op2_neg;
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DVD_W-1:0]    step_next;
  logic [DATA_W-1:0]   quot_raw, rem_raw;
  logic [DATA_W-1:0]   quot_fix, rem_fix;

  // Operand magnitudes; the most negative value maps onto itself as unsigned.
  always_comb begin
    op1_neg = signed_div & opdata1[DATA_W-1];
    op2_neg = signed_div & opdata2[DATA_W-1];
    op1_abs = op1_neg ? (-opdata1) : opdata1;
    op2_abs = op2_neg ? (-opdata2) : opdata2;
  end

  div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .cur     (dividend_q),
    .divisor (divisor_q),
    .next_c  (step_next)
  );

  // Sign post-correction of the finished magnitude result.
  always_comb begin
    quot_raw = dividend_q[DATA_W-1:0];
    rem_raw  = dividend_q[2*DATA_W:DATA_W+1];
    quot_fix = neg_quot_q ? (-quot_raw) : quot_raw;
    rem_fix  = neg_rem_q  ? (-rem_raw)  : rem_raw;
  end

  // Next-state, work registers, result and stall request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    stallreq   = 1'b0;

    case (state_q)
      DIV_FREE: begin
        ready_d = DIV_RESULT_NOT_READY;
        if (start && !annul) begin
          stallreq = 1'b1;
          if (opdata2 == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dividend_d = {{DATA_W{1'b0}}, op1_abs, 1'b0};
            divisor_d  = op2_abs;
            neg_quot_d = op1_neg ^ op2_neg;
            neg_rem_d  = op1_neg;
          end
        end
      end

      DIV_BYZERO: begin
        stallreq = 1'b1;
        if (annul) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        stallreq = 1'b1;
        if (annul) begin
          state_d = DIV_FREE;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          dividend_d = step_next;
          cnt_d      = cnt_q + CNT_W'(1);
        end else begin
          state_d  = DIV_END;
          result_d = {rem_fix, quot_fix};
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_END: begin
        if (!start || annul) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule
